// File: rtl/fec_frame_encoder_if.sv
// Frame-in / result-out bundle for fec_frame_encoder.
// The diag_p signal exists only when FEC_DIAG_PARITY_EN is defined.
interface fec_frame_encoder_if #(
  parameter int unsigned NUM_BYTES = 7,
  parameter int unsigned CRC_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_BYTES*8-1:0] data_in;
  logic [7:0]             msg_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [CRC_WIDTH-1:0]   crc_out;
  logic [NUM_BYTES:0]     row_p;
  logic [7:0]             col_p;
  logic                   len_err;
  logic                   busy;
`ifdef FEC_DIAG_PARITY_EN
  logic [7:0]             diag_p;

  modport master (
    output in_valid, data_in, msg_len, out_ready,
    input  in_ready, out_valid, crc_out, row_p, col_p, len_err, busy, diag_p
  );
  modport slave (
    input  in_valid, data_in, msg_len, out_ready,
    output in_ready, out_valid, crc_out, row_p, col_p, len_err, busy, diag_p
  );
`else
  modport master (
    output in_valid, data_in, msg_len, out_ready,
    input  in_ready, out_valid, crc_out, row_p, col_p, len_err, busy
  );
  modport slave (
    input  in_valid, data_in, msg_len, out_ready,
    output in_ready, out_valid, crc_out, row_p, col_p, len_err, busy
  );
`endif
endinterface

// File: rtl/fec_frame_encoder.sv
// CRC + 2D row/column parity encoder for one byte frame at a time.
// Optional diagonal parity output enabled by defining FEC_DIAG_PARITY_EN.
module fec_frame_encoder #(
  parameter int unsigned NUM_BYTES      = 7,
  parameter int unsigned CRC_WIDTH      = 8,
  parameter logic [7:0]  CRC_POLY       = 8'h07,
  parameter logic [7:0]  CRC_SEED       = 8'h00,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input logic                clk,
  input logic                rst,
  fec_frame_encoder_if.slave bus
);

  localparam int unsigned TOTAL = 8 * NUM_BYTES;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned ROW_W = $clog2(NUM_BYTES + 1);
  localparam logic [CRC_WIDTH-1:0] POLY_W = CRC_POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] SEED_W = CRC_SEED[CRC_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, CRC, PAR, DONE} state_t;

  state_t                 state_q, state_d;
  logic [TOTAL-1:0]       data_q, data_d;
  logic [TOTAL-1:0]       dsh_q, dsh_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [CRC_WIDTH-1:0]   crc_out_q, crc_out_d;
  logic [NUM_BYTES:0]     row_p_q, row_p_d;
  logic [7:0]             col_p_q, col_p_d;
  logic                   len_err_q, len_err_d;
  logic                   in_ready_q, out_valid_q, busy_q;

  logic [7:0]             len_c;
  logic [TOTAL-1:0]       masked_c;
  logic [CRC_WIDTH-1:0]   crc_v;
  logic                   crc_last_c;
  logic [NUM_BYTES:0][7:0] mat_c;
  logic [7:0]             row_c;

  // Matrix view: payload rows then the CRC row zero-extended to a byte.
  assign mat_c      = {8'(crc_out_q), data_q};
  assign row_c      = mat_c[row_q];
  assign crc_last_c = (rem_q <= CNT_W'(BITS_PER_CYCLE));

  // Clamp the length and zero the bytes beyond it.
  always_comb begin
    masked_c = '0;
    len_c    = (bus.msg_len > 8'(NUM_BYTES)) ? 8'(NUM_BYTES) : bus.msg_len;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      masked_c[8*k +: 8] = (8'(k) < len_c) ? bus.data_in[8*k +: 8] : 8'h00;
    end
  end

  // Serial CRC step over up to BITS_PER_CYCLE of the remaining MSB-first bits.
  always_comb begin
    crc_v = crc_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (CNT_W'(i) < rem_q) begin
        crc_v = (crc_v << 1) ^ ((crc_v[CRC_WIDTH-1] ^ dsh_q[TOTAL-1-i]) ? POLY_W : '0);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dsh_d     = dsh_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    row_d     = row_q;
    crc_out_d = crc_out_q;
    row_p_d   = row_p_q;
    col_p_d   = col_p_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d    = masked_c;
          dsh_d     = masked_c;
          rem_d     = CNT_W'(TOTAL);
          crc_d     = SEED_W;
          len_err_d = (bus.msg_len > 8'(NUM_BYTES));
          state_d   = CRC;
        end
      end
      CRC: begin
        crc_d = crc_v;
        dsh_d = dsh_q << BITS_PER_CYCLE;
        rem_d = rem_q - CNT_W'(BITS_PER_CYCLE);
        if (crc_last_c) begin
          crc_out_d = crc_v;
          row_d     = '0;
          col_p_d   = '0;
          state_d   = PAR;
        end
      end
      PAR: begin
        row_p_d[row_q] = ^row_c;
        col_p_d        = col_p_q ^ row_c;
        if (row_q == ROW_W'(NUM_BYTES)) begin
          state_d = DONE;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dsh_q       <= '0;
      rem_q       <= '0;
      crc_q       <= '0;
      row_q       <= '0;
      crc_out_q   <= '0;
      row_p_q     <= '0;
      col_p_q     <= '0;
      len_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dsh_q       <= dsh_d;
      rem_q       <= rem_d;
      crc_q       <= crc_d;
      row_q       <= row_d;
      crc_out_q   <= crc_out_d;
      row_p_q     <= row_p_d;
      col_p_q     <= col_p_d;
      len_err_q   <= len_err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.row_p     = row_p_q;
  assign bus.col_p     = col_p_q;
  assign bus.len_err   = len_err_q;

`ifdef FEC_DIAG_PARITY_EN
  logic [7:0] diag_q, diag_d;

  // Diagonal parity: bit d collects row[r][(r+d) mod 8].
  always_comb begin
    diag_d = diag_q;
    if (state_q == CRC && crc_last_c) begin
      diag_d = '0;
    end else if (state_q == PAR) begin
      for (int d = 0; d < 8; d++) begin
        diag_d[d] = diag_q[d] ^ row_c[3'(row_q) + 3'(d)];
      end
    end
  end

  // Diagonal parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diag_q <= '0;
    end else begin
      diag_q <= diag_d;
    end
  end

  assign bus.diag_p = diag_q;
`endif

endmodule

// File: tb/tb_fec_frame_encoder.sv
// Directed testbench for fec_frame_encoder: vector table plus handshake,
// back-pressure and mid-frame reset sequences.
module tb_fec_frame_encoder;

  localparam int unsigned NB  = 7;
  localparam int unsigned BPC = 8;
  localparam int          LAT = (8 * NB + BPC - 1) / BPC + NB + 1;
  localparam int          MAX_WAIT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fec_frame_encoder_if #(.NUM_BYTES(NB), .CRC_WIDTH(8)) bus();

  fec_frame_encoder #(
    .NUM_BYTES(NB), .CRC_WIDTH(8), .CRC_POLY(8'h07),
    .CRC_SEED(8'h00), .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [8*NB-1:0] data;
    logic [7:0]      len;
    logic [7:0]      crc;
    logic [7:0]      row_p;
    logic [7:0]      col_p;
    logic            len_err;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present a frame at the current negedge; return at the negedge after accept.
  task automatic send(input logic [8*NB-1:0] d, input logic [7:0] len);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.msg_len  = len;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [8*NB-1:0] all_ff;
    logic stable;
    logic quiet;

    all_ff = '1;
    //           data      len    crc    row_p  col_p  err
    vecs[0] = '{56'h0,     8'd7, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{56'h01,    8'd7, 8'h07, 8'h81, 8'h06, 1'b0};
    vecs[2] = '{all_ff,    8'd1, 8'hF3, 8'h00, 8'h0C, 1'b0};
    vecs[3] = '{all_ff,    8'd9, 8'h0C, 8'h00, 8'hF3, 1'b1};
    vecs[4] = '{all_ff,    8'd7, 8'h0C, 8'h00, 8'hF3, 1'b0};
    vecs[5] = '{56'h01,    8'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{56'h0100,  8'd7, 8'h15, 8'h82, 8'h14, 1'b0};
    vecs[7] = '{56'h0100,  8'd1, 8'h00, 8'h00, 8'h00, 1'b0};

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.msg_len   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_state",
          {bus.in_ready, bus.out_valid, bus.busy, bus.len_err, bus.crc_out, bus.row_p, bus.col_p},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].len);
      wait_out(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_crc", i), bus.crc_out, vecs[i].crc);
      check($sformatf("v%0d_row_p", i), bus.row_p, vecs[i].row_p);
      check($sformatf("v%0d_col_p", i), bus.col_p, vecs[i].col_p);
      check($sformatf("v%0d_len_err", i), bus.len_err, vecs[i].len_err);
      check($sformatf("v%0d_busy_rdy", i), {bus.busy, bus.in_ready}, 2'b10);
`ifdef FEC_DIAG_PARITY_EN
      if (i == 1) check("v1_diag", bus.diag_p, 8'h0F);
`endif
      release_out();
      check($sformatf("v%0d_release", i), {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
      @(negedge clk);
    end

    // Back-pressure: hold out_ready low for 20 cycles
    send(vecs[1].data, vecs[1].len);
    wait_out(lat);
    check("hold_latency", 64'(lat), 64'(LAT));
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.crc_out === 8'h07 &&
            bus.row_p === 8'h81 && bus.col_p === 8'h06 && bus.len_err === 1'b0))
        stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    release_out();
    check("hold_release", {bus.out_valid, bus.in_ready}, 2'b01);

    // Back-to-back frame in the first IDLE cycle
    send(vecs[2].data, vecs[2].len);
    wait_out(lat);
    check("b2b_latency", 64'(lat), 64'(LAT));
    check("b2b_crc", bus.crc_out, 8'hF3);
    check("b2b_col_p", bus.col_p, 8'h0C);
    release_out();
    @(negedge clk);

    // Reset asserted during the 5th CRC cycle
    send(vecs[1].data, vecs[1].len);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_state",
          {bus.in_ready, bus.out_valid, bus.busy, bus.len_err, bus.crc_out, bus.row_p, bus.col_p},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 1'b0;
    end
    check("midrst_no_partial", quiet, 1'b1);
    send(vecs[1].data, vecs[1].len);
    wait_out(lat);
    check("postrst_latency", 64'(lat), 64'(LAT));
    check("postrst_crc", bus.crc_out, 8'h07);
    check("postrst_row_p", bus.row_p, 8'h81);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
